// File: rtl/cyber_pkg.sv
// Shared types and constants for the cyber_player computer opponent.
package cyber_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} cyber_state_t;

  localparam int CYBER_LFSR_W   = 10;
  // 1-based Fibonacci tap positions (x^10 + x^7)
  localparam int LFSR_TAP_A     = 10;
  localparam int LFSR_TAP_B     = 7;
  localparam int CYBER_TICK_DIV = 25_000_000;
endpackage

// File: rtl/cyber_player_if.sv
// Game-side bus of the cyber opponent. CYBER_LEVEL_OUT_EN adds key_level.
interface cyber_player_if #(parameter int LFSR_W = cyber_pkg::CYBER_LFSR_W);
  logic              enable;
  logic [LFSR_W-2:0] threshold;
  logic              press;
  logic              busy;
`ifdef CYBER_LEVEL_OUT_EN
  logic              key_level;
  modport master (input enable, threshold, output press, busy, key_level);
  modport slave  (output enable, threshold, input press, busy, key_level);
`else
  modport master (input enable, threshold, output press, busy);
  modport slave  (output enable, threshold, input press, busy);
`endif
endinterface

// File: rtl/lfsr10.sv
// XNOR Fibonacci LFSR, taps 10,7. Resets to zero; all-ones is the unreachable lockup state.
module lfsr10 import cyber_pkg::*; #(
  parameter int W = CYBER_LFSR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] out
);
  always_ff @(posedge clk) begin
    if (reset)    out <= '0;
    else if (adv) out <= {out[W-2:0], ~(out[LFSR_TAP_A-1] ^ out[LFSR_TAP_B-1])};
  end
endmodule

// File: rtl/cyber_player.sv
// Computer opponent: emits one-cycle press strobes at an LFSR/threshold-driven rate.
// Optional macro CYBER_LEVEL_OUT_EN exposes the raw virtual key level.
module cyber_player import cyber_pkg::*; #(
  parameter int LFSR_W      = CYBER_LFSR_W,
  parameter int TICK_DIV    = CYBER_TICK_DIV,
  parameter int PRESS_TICKS = 2
) (
  input  logic clk,
  input  logic reset,
  cyber_player_if.master bus
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (PRESS_TICKS > 1) ? $clog2(PRESS_TICKS) : 1;

  logic [DW-1:0]     div_cnt;
  logic              tick;
  logic [LFSR_W-1:0] lfsr;
  logic              win;
  cyber_state_t      state, state_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic              press_n, press_q, busy_q;

  assign tick = (div_cnt == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  lfsr10 #(.W(LFSR_W)) u_lfsr (.clk(clk), .reset(reset), .adv(tick), .out(lfsr));

  // Decision uses the value before this tick's advance.
  assign win = ({1'b0, bus.threshold} > lfsr);

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    press_n = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      hold_n  = '0;
    end else if (tick) begin
      case (state)
        IDLE: if (win) begin
          state_n = HOLD;
          hold_n  = HW'(PRESS_TICKS - 1);
          press_n = 1'b1;
        end
        HOLD: if (hold_cnt == '0) state_n = RELEASE;
              else                hold_n  = hold_cnt - 1'b1;
        RELEASE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      press_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      press_q  <= press_n;
      busy_q   <= (state_n != IDLE);
    end
  end

  assign bus.press = press_q;
  assign bus.busy  = busy_q;

`ifdef CYBER_LEVEL_OUT_EN
  logic key_q;
  always_ff @(posedge clk) begin
    if (reset) key_q <= 1'b0;
    else       key_q <= (state_n == HOLD);
  end
  assign bus.key_level = key_q;
`endif
endmodule

// File: tb/tb_cyber_player.sv
// Randomized self-checking bench for cyber_player against a tick-level behavioural model.
module tb_cyber_player;
  localparam int TD = 4, PT = 2, LW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cyber_player_if #(.LFSR_W(LW)) bus();
  cyber_player #(.LFSR_W(LW), .TICK_DIV(TD), .PRESS_TICKS(PT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0, n_pass = 0;
  // model: cycles since reset, lfsr value, ticks left until the player is free again
  int cyc = 0, l = 0, left = 0;
  bit e_press = 0;
  int tcyc = 0, last_p = -1, min_gap = 1 << 30, n_press = 0, n_busy = 0, n_zero = 0;
  bit saw_ones = 0;
  logic [3:0] kh = '0;
  logic [2:0] ph = '0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int lnext(input int v);
    return ((v << 1) & 1023) | (~((v >> 9) ^ (v >> 6)) & 1);
  endfunction

  task automatic step();
    bit tk;
    @(posedge clk);
    if (reset) begin
      cyc = 0; l = 0; left = 0; e_press = 0;
    end else begin
      tk = (cyc % TD) == TD - 1;
      cyc++;
      e_press = 0;
      if (!bus.enable) left = 0;
      else if (tk) begin
        if (left > 0) left--;
        else if (int'(bus.threshold) > l) begin
          left = PT + 1;
          e_press = 1;
        end
      end
      if (tk) l = lnext(l);
    end
    @(negedge clk);
    tcyc++;
    chk("press", int'(bus.press), int'(e_press));
    chk("busy", int'(bus.busy), int'(left > 0));
    chk("lfsr", int'(dut.u_lfsr.out), l);
`ifdef CYBER_LEVEL_OUT_EN
    chk("key_level", int'(bus.key_level), int'(left > 1));
    kh = {kh[2:0], bus.key_level};
    ph = {ph[1:0], bus.press};
    chk("edge_path", int'(kh[2] & ~kh[3]), int'(ph[2]));
`endif
    if (bus.press) begin
      if (last_p >= 0 && tcyc - last_p < min_gap) min_gap = tcyc - last_p;
      last_p = tcyc;
      n_press++;
    end
    if (bus.busy) n_busy++;
    if (dut.u_lfsr.out == '1) saw_ones = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("rst_press", int'(bus.press), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_lfsr", int'(dut.u_lfsr.out), 0);
    step();
    reset = 1'b0;
  endtask

  task automatic wait_press(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.press) begin ok = 1; break; end
    end
  endtask

  initial begin
    bit ok;
    int first;
    bus.enable = 1'b0;
    bus.threshold = '0;

    // threshold 0: never presses
    bus.enable = 1'b1;
    do_reset();
    n_press = 0; n_busy = 0;
    for (int i = 0; i < 5000; i++) step();
    chk("thr0_presses", n_press, 0);
    chk("thr0_busy", n_busy, 0);

    // threshold 1: first press one cycle after the first tick, next one a full period later
    bus.threshold = 9'd1;
    do_reset();
    n_press = 0; first = -1; saw_ones = 0; n_zero = 0;
    for (int k = 1; k <= 4 * 1023 + 8; k++) begin
      step();
      if (bus.press && first < 0) first = k;
      if (k >= TD && k < 4 * 1023 && dut.u_lfsr.out == '0) n_zero++;
      if (k == 4 * 1023) chk("lfsr_period", int'(dut.u_lfsr.out), 0);
    end
    chk("first_press_edge", first, TD);
    chk("thr1_presses", n_press, 2);
    chk("lfsr_early_zero", n_zero, 0);
    chk("lfsr_all_ones", int'(saw_ones), 0);

    // max threshold: spacing never below (PT+2) ticks
    bus.threshold = 9'd511;
    do_reset();
    n_press = 0; last_p = -1; min_gap = 1 << 30;
    for (int i = 0; i < 3000; i++) step();
    chk("max_thr_pressed", int'(n_press > 10), 1);
    chk("min_gap", int'(min_gap >= (PT + 2) * TD), 1);

    // enable dropped mid-HOLD, then re-enabled
    wait_press(200, ok);
    chk("hold_press_seen", int'(ok), 1);
    step(); step();
    bus.enable = 1'b0;
    step();
    chk("dis_busy", int'(bus.busy), 0);
    chk("dis_press", int'(bus.press), 0);
`ifdef CYBER_LEVEL_OUT_EN
    chk("dis_key", int'(bus.key_level), 0);
`endif
    for (int i = 0; i < 20; i++) step();
    chk("dis_idle_presses", int'(bus.busy), 0);
    bus.enable = 1'b1;
    wait_press(2000, ok);
    chk("reen_press", int'(ok), 1);

    // reset asserted mid-HOLD
    step(); step();
    reset = 1'b1;
    step();
    chk("rhold_press", int'(bus.press), 0);
    chk("rhold_busy", int'(bus.busy), 0);
    chk("rhold_lfsr", int'(dut.u_lfsr.out), 0);
`ifdef CYBER_LEVEL_OUT_EN
    chk("rhold_key", int'(bus.key_level), 0);
`endif
    reset = 1'b0;

    // random thresholds, enable toggles and occasional resets
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 3))
        0:       bus.threshold = 9'd0;
        1:       bus.threshold = 9'd511;
        default: bus.threshold = 9'($urandom_range(1, 510));
      endcase
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 99) < 3) bus.enable = ~bus.enable;
        reset = ($urandom_range(0, 999) < 2);
        step();
      end
    end
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cyber_player.md
# cyber_player

Computer opponent for the tug-of-war light game. It generates player key presses as one-cycle pulses with the same meaning as the edge-detected human key strobes, so the game sees it as one of its two players. Press rate comes from a 10-bit LFSR compared against a switch-set difficulty threshold. A press/hold/release state machine enforces realistic press spacing.

## Interface
- `LFSR_W`, default 10: LFSR width; `threshold` is `LFSR_W-1` bits wide.
- `TICK_DIV`, default 25_000_000: clock cycles per decision tick. Benches override it to 4.
- `PRESS_TICKS`, default 2: number of ticks the virtual key stays held after a press.
- `clk`, input, 1: system clock (CLOCK_50 domain); the only clock.
- `reset`, input, 1: synchronous, active-high; driven from SW[9].
- `enable`, input, 1: 1 = opponent plays; 0 = frozen (game over or idle).
- `threshold`, input, `LFSR_W-1`: difficulty from SW[8:0]; larger value means more frequent presses.
- `press`, output, 1: one-cycle press strobe; drives a light chain's L or R input.
- `busy`, output, 1: high while in HOLD or RELEASE.
- `key_level`, output, 1: raw active-high virtual key level. Present only under `CYBER_LEVEL_OUT_EN`.

## Operation
- Prescaler `div_cnt` counts 0..`TICK_DIV-1` and then wraps.
  - `tick` is internal and high for exactly one cycle when `div_cnt == TICK_DIV-1`.
- The LFSR is XNOR Fibonacci with taps 10,7.
  - Next value = `{lfsr[8:0], ~(lfsr[9] ^ lfsr[6])}`.
  - It advances on every tick regardless of `enable` or state.
  - All-zero is a legal state; all-ones is the lockup state and is unreachable from reset.
  - Period is 1023.
- Decision: `win = ({1'b0, threshold} > lfsr)`, using the pre-advance LFSR value on that tick. The comparison is unsigned and `LFSR_W` bits wide.
- FSM states: IDLE, HOLD, RELEASE.
  - IDLE: on `tick & enable & win`, go to HOLD, assert `press` for one cycle, and load `hold_cnt = PRESS_TICKS-1`.
  - HOLD: on each tick, if `hold_cnt == 0` go to RELEASE; otherwise decrement `hold_cnt`.
  - RELEASE: on the next tick go to IDLE. No decision is evaluated on that tick.
  - Consequence: minimum press-to-press spacing is `PRESS_TICKS+2` ticks.
- `enable` low in any state: next cycle the FSM is IDLE, `press`=0, `busy`=0. The LFSR and prescaler keep running.
- `threshold` = 0: `win` is never true, so there are no presses.
- Maximum `threshold`: the FSM presses on every IDLE tick where `lfsr < threshold`.
- Reset, including mid-HOLD: state IDLE, `div_cnt`=0, `lfsr`=0, `hold_cnt`=0, `press`=0, `busy`=0, `key_level`=0.

## Timing
- All outputs are registered.
- `press` rises in the cycle after the deciding tick cycle and is high for exactly one clock.
- `busy` rises together with `press`. It falls in the cycle after the tick that leaves RELEASE.
- The first tick occurs `TICK_DIV` cycles after reset deasserts.
- The first decision uses `lfsr`=0, so any nonzero `threshold` presses on the first tick.
- `enable` deasserting in the same cycle as a winning tick suppresses the press.

## Configuration
- `CYBER_LEVEL_OUT_EN` defined:
  - Adds the `key_level` port.
  - `key_level` is 1 throughout HOLD, from the cycle `press` rises until the cycle after the final HOLD tick.
  - `key_level` is 0 in IDLE and RELEASE.
  - This lets the level feed the same DFlipFlop → UserInput path as a physical key; the edge detector output must then match `press` delayed by 2 cycles.
- Not defined: no `key_level` port and no related logic. Only `press` is used.

## Structure
- Shared package `cyber_pkg`: FSM state enum `cyber_state_t` (IDLE, HOLD, RELEASE), LFSR tap constants, default `TICK_DIV`.
- One natural sub-module: `lfsr10` (clk, reset, adv, out). It contains the XNOR feedback and reset-to-zero; `cyber_player` instantiates it with `adv = tick`.

## Test plan
All scenarios use `TICK_DIV`=4 and `PRESS_TICKS`=2.
- Reset then `threshold`=0, `enable`=1 for 5000 cycles → `press` never asserts; `busy` stays 0.
- `threshold`=1, `enable`=1 from reset → `press` high in exactly cycle 5 after reset release, for one cycle. No further press until `lfsr` returns to 0, 1023 ticks later.
- `threshold`=511 → consecutive `press` rising edges are never closer than 16 cycles (4 ticks); `busy` covers HOLD+RELEASE exactly.
- LFSR check → after 1023 ticks the LFSR equals 0 again and never equals all-ones.
- `enable` dropped mid-HOLD → next cycle state IDLE, `busy`=0, `key_level`=0. Re-enabling yields presses on subsequent winning ticks.
- `reset` asserted mid-HOLD with `CYBER_LEVEL_OUT_EN` → next cycle all outputs 0 and `lfsr`=0. Separately, feeding `key_level` through DFlipFlop+UserInput reproduces `press` delayed by 2 cycles.
